// File: rtl/counter_checker_pkg.sv
// Shared types and default sizing for the receive-side counter checker.
package counter_checker_pkg;

  typedef enum logic [0:0] {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } state_t;

  localparam int CNT_WIDTH       = 4;
  localparam int LOCK_CYCLES_DEF = 4;
  localparam int ERR_W_DEF       = 8;

endpackage

// File: rtl/counter_checker_sat_counter.sv
// Event counter that either saturates at all-ones or rolls over, selected by saturate.
module sat_counter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              saturate,
  output logic [DATA_W-1:0] count
);

  function automatic logic [DATA_W-1:0] next_count(input logic [DATA_W-1:0] cur,
                                                   input logic              sat);
    if (sat && (cur == '1)) return cur;
    return cur + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= next_count(count, saturate);
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Predicts the next value of an enable counter from its last sample, locks once the
// prediction holds, then reports divergences and counts wrap-arounds.
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int WIDTH       = CNT_WIDTH,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int ERR_W       = ERR_W_DEF
) (
  input  logic             clock_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] counter_value_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             mismatch_o,
  output logic             error_o,
  output logic [ERR_W-1:0] error_count_o,
  output logic [ERR_W-1:0] wrap_count_o
);

  localparam int MCNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(LOCK_CYCLES - 1);

  logic [WIDTH-1:0]  val_p1;
  logic              en_p1;
  logic              vld_p1;
  state_t            state;
  logic [MCNT_W-1:0] mcnt;
  logic              mismatch_q;
  logic              error_q;

  logic [WIDTH-1:0]  expected;
  logic              compare;
  logic              match;
  logic              locked;
  logic              err_event;
  logic              wrap_event;

  // Stage p1: last observed value and enable; these re-base the predictor every cycle.
  always_ff @(posedge clock_i) begin
    val_p1 <= counter_value_i;
    en_p1  <= enable_i;
  end

  assign expected   = val_p1 + WIDTH'(en_p1);
  assign compare    = vld_p1 && !clear_i;
  assign match      = (counter_value_i == expected);
  assign locked     = (state == ST_LOCKED);
  assign err_event  = compare && locked && !match;
  assign wrap_event = compare && locked && match && (val_p1 == '1) && en_p1 &&
                      (counter_value_i == '0);

  // Stage p2: lock state machine and registered flags.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vld_p1     <= 1'b0;
      state      <= ST_ACQUIRE;
      mcnt       <= '0;
      mismatch_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      vld_p1     <= !clear_i;
      mismatch_q <= err_event;
      if (clear_i) begin
        state   <= ST_ACQUIRE;
        mcnt    <= '0;
        error_q <= 1'b0;
      end else if (vld_p1) begin
        case (state)
          ST_ACQUIRE: begin
            if (!match) begin
              mcnt <= '0;
            end else if (mcnt == MCNT_LAST) begin
              state <= ST_LOCKED;
              mcnt  <= '0;
            end else begin
              mcnt <= mcnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!match) begin
              state   <= ST_ACQUIRE;
              mcnt    <= '0;
              error_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  sat_counter #(.DATA_W(ERR_W)) u_err_cnt (
    .clk      (clock_i),
    .rst_n    (reset_n_i),
    .clr      (clear_i),
    .inc      (err_event),
    .saturate (1'b1),
    .count    (error_count_o)
  );

  sat_counter #(.DATA_W(ERR_W)) u_wrap_cnt (
    .clk      (clock_i),
    .rst_n    (reset_n_i),
    .clr      (clear_i),
    .inc      (wrap_event),
    .saturate (1'b0),
    .count    (wrap_count_o)
  );

  assign locked_o   = locked;
  assign mismatch_o = mismatch_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: directed scenarios plus random traffic against a behavioural model.
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] cval;
  logic       clr;

  logic       locked_b, mis_b, err_b;
  logic [7:0] ecnt_b, wcnt_b;
  logic       locked_s, mis_s, err_s;
  logic [1:0] ecnt_s, wcnt_s;

  int total = 0;
  int bad   = 0;
  int pulses_s = 0;

  // Behavioural model state
  bit m_vld, m_pen, m_lock, m_err, m_pulse;
  int m_prev, m_streak, m_errs, m_wraps;

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(4), .LOCK_CYCLES(4), .ERR_W(8)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(en), .counter_value_i(cval), .clear_i(clr),
    .locked_o(locked_b), .mismatch_o(mis_b), .error_o(err_b),
    .error_count_o(ecnt_b), .wrap_count_o(wcnt_b)
  );

  counter_checker #(.WIDTH(4), .LOCK_CYCLES(4), .ERR_W(2)) dut_s (
    .clock_i(clk), .reset_n_i(rst_n), .enable_i(en), .counter_value_i(cval), .clear_i(clr),
    .locked_o(locked_s), .mismatch_o(mis_s), .error_o(err_s),
    .error_count_o(ecnt_s), .wrap_count_o(wcnt_s)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_vld = 0; m_lock = 0; m_err = 0; m_pulse = 0;
    m_streak = 0; m_errs = 0; m_wraps = 0;
  endfunction

  function automatic int good_next();
    return (m_prev + m_pen) % 16;
  endfunction

  function automatic void model_step(bit e, int v, bit c);
    bit hit;
    hit = (v == (m_prev + m_pen) % 16);
    m_pulse = 0;
    if (c) begin
      m_lock = 0; m_streak = 0; m_err = 0; m_errs = 0; m_wraps = 0;
    end else if (m_vld) begin
      if (!m_lock) begin
        if (hit) begin
          m_streak++;
          if (m_streak == 4) begin
            m_lock = 1;
            m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end else if (hit) begin
        if (m_prev == 15 && m_pen && v == 0) m_wraps++;
      end else begin
        m_pulse = 1; m_err = 1; m_errs++; m_lock = 0; m_streak = 0;
      end
    end
    m_vld = !c;
    m_prev = v;
    m_pen = e;
  endfunction

  task automatic cycle(input bit e, input int v, input bit c);
    en = e; cval = 4'(v); clr = c;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(e, v, c);
    #1;
    if (mis_s) pulses_s++;
    check("locked", locked_b, m_lock);
    check("locked_s", locked_s, m_lock);
    check("mismatch", mis_b, m_pulse);
    check("mismatch_s", mis_s, m_pulse);
    check("error", err_b, m_err);
    check("error_s", err_s, m_err);
    check("err_cnt", ecnt_b, (m_errs > 255) ? 255 : m_errs);
    check("err_cnt_s", ecnt_s, (m_errs > 3) ? 3 : m_errs);
    check("wrap_cnt", wcnt_b, m_wraps % 256);
    check("wrap_cnt_s", wcnt_s, m_wraps % 4);
  endtask

  function automatic int wrong_next();
    return (good_next() + 1 + $urandom_range(0, 14)) % 16;
  endfunction

  task automatic lock_up();
    int g = 0;
    while (!m_lock && g < 40) begin
      cycle(1, good_next(), 0);
      g++;
    end
    check("lock_up", locked_b, 1);
  endtask

  initial begin
    rst_n = 0; en = 0; cval = 0; clr = 0;
    model_reset();
    m_prev = 0; m_pen = 0;
    repeat (3) cycle(0, 0, 0);
    check("rst_locked", locked_b, 0);
    check("rst_err_cnt", ecnt_b, 0);
    check("rst_wrap_cnt", wcnt_b, 0);
    rst_n = 1;

    // Reset then lock, continuing through a wrap
    for (int v = 0; v <= 5; v++) begin
      cycle(1, v, 0);
      if (v == 3) check("lock_early", locked_b, 0);
      if (v == 4) check("lock_on_time", locked_b, 1);
    end
    for (int v = 6; v <= 15; v++) cycle(1, v, 0);
    cycle(1, 0, 0);
    check("wrap_once", wcnt_b, 1);
    check("wrap_no_err", err_b, 0);

    // Single mismatch at 6 -> 9, then re-lock from 9
    for (int v = 1; v <= 6; v++) cycle(1, v, 0);
    cycle(1, 9, 0);
    check("mm_pulse", mis_b, 1);
    check("mm_unlock", locked_b, 0);
    check("mm_err_cnt", ecnt_b, 1);
    cycle(1, 10, 0);
    check("mm_one_cycle", mis_b, 0);
    for (int v = 11; v <= 13; v++) cycle(1, v, 0);
    check("relock", locked_b, 1);

    // Hold at 5 with enable low, then an unexpected step
    for (int v = 14; v <= 15; v++) cycle(1, v, 0);
    for (int v = 0; v <= 4; v++) cycle(1, v, 0);
    check("wrap_twice_s", wcnt_s, 2);
    for (int i = 0; i < 10; i++) cycle(0, 5, 0);
    check("hold_locked", locked_b, 1);
    check("hold_err_cnt", ecnt_b, 1);
    cycle(0, 6, 0);
    check("hold_mm", mis_b, 1);
    check("hold_err_cnt2", ecnt_b, 2);

    // Random traffic with occasional corruption and clears
    for (int i = 0; i < 400; i++) begin
      bit e, c, corrupt;
      e = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 49) == 0);
      corrupt = ($urandom_range(0, 9) == 0);
      cycle(e, corrupt ? wrong_next() : good_next(), c);
    end

    // Saturation on the narrow counter, then clear beating a mismatch
    cycle(1, good_next(), 1);
    pulses_s = 0;
    for (int k = 0; k < 5; k++) begin
      lock_up();
      cycle(1, wrong_next(), 0);
    end
    check("sat_pulses", pulses_s, 5);
    check("sat_cnt_s", ecnt_s, 3);
    check("sat_cnt_b", ecnt_b, 5);
    lock_up();
    cycle(1, wrong_next(), 1);
    check("clr_no_pulse", mis_b, 0);
    check("clr_err", err_b, 0);
    check("clr_err_cnt", ecnt_b, 0);
    check("clr_err_cnt_s", ecnt_s, 0);

    // Asynchronous reset while locked with error set
    lock_up();
    cycle(1, wrong_next(), 0);
    lock_up();
    check("pre_rst_err", err_b, 1);
    #2 rst_n = 0;
    #1;
    check("async_locked", locked_b, 0);
    check("async_error", err_b, 0);
    check("async_locked_s", locked_s, 0);
    model_reset();
    repeat (2) cycle(1, 0, 0);
    rst_n = 1;
    lock_up();
    for (int i = 0; i < 20; i++) cycle(1, good_next(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
# counter_checker

Receive-side monitor for the 4-bit enable counter on the board. It samples the counter's output value together with the enable that was driven into it, predicts the next value, and locks once the two agree. After lock it flags every divergence with a one-cycle pulse, a sticky flag and a saturating error count, and it counts wrap-arounds. It sits beside the counter in the top level and gives a self-check for bring-up and silicon test.

## Interface
- `WIDTH`, 4: width of the observed counter value.
- `LOCK_CYCLES`, 4: consecutive matching comparisons required to lock (1..15).
- `ERR_W`, 8: width of the error and wrap counters.

Ports:
- `clock_i` in 1: single clock, the same clock that drives the counter.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `enable_i` in 1: the enable driven to the counter in the same cycle.
- `counter_value_i` in `WIDTH`: the counter's registered output.
- `clear_i` in 1: synchronous clear of state, flags and counters.
- `locked_o` out 1: predictor is locked.
- `mismatch_o` out 1: one-cycle pulse on a mismatch while locked.
- `error_o` out 1: sticky, set by any mismatch while locked.
- `error_count_o` out `ERR_W`: number of mismatches while locked; saturates at all-ones.
- `wrap_count_o` out `ERR_W`: number of locked wraps from all-ones to 0; rolls over modulo 2^`ERR_W`.

## Operation
**Sample registers.** On every edge the block captures `prev_val` ← `counter_value_i` and `prev_en` ← `enable_i`. A `valid` bit is set after the first capture following reset or clear.

**Prediction.** `expected = prev_val + prev_en`, computed modulo 2^`WIDTH` (carry dropped). A cycle is a comparison cycle when `valid` = 1. It is a match when `counter_value_i == expected`.

**State machine** (2 states):
- ACQUIRE (reset state), with a match counter `mcnt`:
  - Match: `mcnt` increments.
  - Mismatch: `mcnt` returns to 0. Not counted as an error.
  - When `mcnt` reaches `LOCK_CYCLES`: go to LOCKED and clear `mcnt`.
- LOCKED:
  - Match: stay in LOCKED.
  - Match where `prev_val` is all-ones, `prev_en` = 1 and `counter_value_i` = 0: increment `wrap_count_o`.
  - Mismatch: pulse `mismatch_o`, set `error_o`, increment `error_count_o` (saturating), then return to ACQUIRE with `mcnt` = 0. The predictor re-bases on the observed value because `prev_val` always holds the last observed value.

**clear_i.**
- Effect: returns to ACQUIRE and clears `valid`, `mcnt`, `error_o`, `error_count_o` and `wrap_count_o`.
- Priority: `clear_i` beats a mismatch or wrap in the same cycle, so that event is not recorded.
- Sampling: `prev_val` and `prev_en` still capture during clear.

**Reset.** All outputs are 0: `locked_o` = 0, `mismatch_o` = 0, `error_o` = 0, both counts 0, state ACQUIRE, `valid` = 0. Reset asserted mid-lock drops `locked_o` immediately (asynchronous).

## Timing
- All outputs are registered.
- If the offending value is presented in cycle k, `mismatch_o` is high in cycle k+1 only, and `locked_o` falls at the same edge.
- `error_o` and the updated `error_count_o` become visible in cycle k+1.
- After reset release, the first comparison happens in the second cycle. With steady correct input, `locked_o` rises `LOCK_CYCLES` + 1 edges after release.
- Saturation: at `error_count_o` = all-ones a further mismatch still pulses `mismatch_o`; the count holds.
- `enable_i` held low: expected equals the held value, which is a match, and lock is maintained.

## Structure
- `counter_checker_pkg` holds:
  - the state enum (`ST_ACQUIRE`, `ST_LOCKED`);
  - the default constants `CNT_WIDTH` = 4, `LOCK_CYCLES_DEF` = 4, `ERR_W_DEF` = 8.
- One sub-module, `sat_counter`: parameterised width, increment/clear inputs, and a saturate-or-wrap select. It is instantiated twice (error count saturating, wrap count wrapping).
- The rest is flat: sample registers, comparator and FSM.

## Test plan
- **Reset then lock:** reset, then enable = 1, counter 0,1,2,3,4,5. Required: `locked_o` rises after 4 matches; no errors; counts 0.
- **Wrap:** locked, enable = 1, counter 14,15,0,1. Required: `wrap_count_o` goes 0→1; `error_o` stays 0.
- **Single mismatch:** locked at value 6 with enable = 1, counter presents 9 instead of 7. Required:
  - `mismatch_o` high exactly one cycle;
  - `error_o` = 1, `error_count_o` = 1, `locked_o` = 0;
  - re-lock after 4 matching steps from 9 (10,11,12,13).
- **Hold:** locked, enable = 0 for 10 cycles, value constant at 5. Required: remains locked with no errors. Then the value changes to 6 while enable = 0. Required: mismatch.
- **Saturation and clear:** with `ERR_W` = 2, force 5 locked mismatches. Required: `error_count_o` = 3, five `mismatch_o` pulses. Then `clear_i` in the same cycle as a further mismatch. Required: all counts 0, `error_o` = 0, no `mismatch_o` pulse.
- **Async reset mid-lock:** while locked, assert `reset_n_i` between clock edges. Required: `locked_o` and `error_o` are 0 before the next edge.
